// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer
//   Runs a multi-byte SPI burst through the IO register map without CPU
//   involvement. Software fills the TX FIFO and pulses go. For each byte the
//   block writes the SPI data register (addr 4) with the start bit set, then
//   writes it again with the start bit clear. It polls the status register
//   (addr 9) through a rising and a falling busy edge, then reads the received
//   byte from addr 4 into the RX FIFO.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   tx_wr/tx_data       TX FIFO push (ignored when tx_full); tx_full flag
//   rx_rd/rx_data       RX FIFO pop (ignored when rx_empty); rx_data is the head entry
//   rx_empty            RX FIFO empty flag
//   go                  start a burst (accepted only in IDLE with TX non-empty)
//   busy, done, err     status: busy outside IDLE, one-cycle done, sticky err
//                       (bit0 timeout, bit1 RX overflow)
//   io_req/io_gnt       bus request/grant with the system arbiter
//   io_cs/io_write/io_read/io_addr/io_dout/io_din  IO register bus
//
// Bus handshake: io_req is held from REQ through READ. A bus cycle takes
// place on every rising edge where the state drives a strobe and io_gnt is
// high. With io_gnt low, all bus outputs are 0 and the FSM holds its state.
module spi_burst_sequencer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_wr,
  input  logic [7:0]  tx_data,
  output logic        tx_full,
  input  logic        rx_rd,
  output logic [7:0]  rx_data,
  output logic        rx_empty,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        io_req,
  input  logic        io_gnt,
  output logic        io_cs,
  output logic        io_write,
  output logic        io_read,
  output logic [13:0] io_addr,
  output logic [15:0] io_dout,
  input  logic [15:0] io_din
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);
  localparam logic [13:0]   ADDR_DATA = 14'd4;
  localparam logic [13:0]   ADDR_STAT = 14'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_CLR, S_WAIT_HI, S_WAIT_LO, S_READ, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [7:0]     byte_q, byte_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [1:0]     err_q, err_d;

  logic [7:0]     tx_mem [DEPTH];
  logic [7:0]     rx_mem [DEPTH];

  logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_full;
  logic [7:0] tx_head;
  logic io_din_unused;

  assign io_din_unused = ^io_din[15:8];
  assign tx_head  = tx_mem[tx_rp_q];
  assign rx_data  = rx_mem[rx_rp_q];
  assign tx_full  = (tx_cnt_q == FIFO_FULL);
  assign rx_full  = (rx_cnt_q == FIFO_FULL);
  assign rx_empty = (rx_cnt_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign io_req   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err      = err_q;

  // Next state, burst bookkeeping and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    byte_d   = byte_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    tx_pop   = 1'b0;
    tx_flush = 1'b0;
    rx_push  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go && (tx_cnt_q != '0)) begin
          state_d = S_REQ;
          rem_d   = tx_cnt_q;   // bytes pushed later wait for the next go
          err_d   = '0;
        end
      end
      S_REQ: begin
        if (io_gnt) state_d = S_LOAD;
      end
      S_LOAD: begin
        // The byte is kept for the CLR write because the pop moves the TX head.
        if (io_gnt) begin
          byte_d  = tx_head;
          tx_pop  = (tx_cnt_q != '0);
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (io_gnt) begin
          tmo_d   = '0;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (io_gnt) begin
          if (io_din[0]) begin
            tmo_d   = '0;
            state_d = S_WAIT_LO;
          end else if (tmo_q == TMO_LAST) begin
            err_d[0] = 1'b1;
            tx_flush = 1'b1;
            state_d  = S_DONE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_WAIT_LO: begin
        if (io_gnt) begin
          if (!io_din[0]) begin
            state_d = S_READ;
          end else if (tmo_q == TMO_LAST) begin
            err_d[0] = 1'b1;
            tx_flush = 1'b1;
            state_d  = S_DONE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_READ: begin
        if (io_gnt) begin
          if (rx_full) err_d[1] = 1'b1;   // byte is dropped, burst continues
          else         rx_push  = 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == CW'(1)) ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    tx_push = tx_wr && !tx_full && !tx_flush;
    rx_pop  = rx_rd && !rx_empty;

    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_flush) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
    end

    rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
  end

  // Bus outputs decoded from the registered state and gated by the grant.
  always_comb begin
    io_cs    = 1'b0;
    io_write = 1'b0;
    io_read  = 1'b0;
    io_addr  = '0;
    io_dout  = '0;
    if (io_gnt) begin
      case (state_q)
        S_LOAD: begin
          io_cs = 1'b1; io_write = 1'b1; io_addr = ADDR_DATA;
          io_dout = {7'b0, 1'b1, tx_head};
        end
        S_CLR: begin
          io_cs = 1'b1; io_write = 1'b1; io_addr = ADDR_DATA;
          io_dout = {7'b0, 1'b0, byte_q};
        end
        S_WAIT_HI, S_WAIT_LO: begin
          io_cs = 1'b1; io_read = 1'b1; io_addr = ADDR_STAT;
        end
        S_READ: begin
          io_cs = 1'b1; io_read = 1'b1; io_addr = ADDR_DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= tx_data;
    if (rx_push) rx_mem[rx_wp_q] <= io_din[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rem_q    <= '0;
      byte_q   <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      rem_q    <= rem_d;
      byte_q   <= byte_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: a loopback SPI IO model, a bus-write
// scoreboard, an RX scoreboard and a TX content model, a table of bursts,
// and hand-written timeout and reset sequences.
module tb_spi_burst_sequencer;
  localparam int DEPTH    = 16;
  localparam int TIMEOUT  = 20;
  localparam int BUSY_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_wr, tx_full, rx_rd, rx_empty, go, busy, done;
  logic [7:0]  tx_data, rx_data;
  logic [1:0]  err;
  logic        io_req, io_gnt, io_cs, io_write, io_read;
  logic [13:0] io_addr;
  logic [15:0] io_dout, io_din;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wr_exp_q[$];
  logic [7:0]  rx_exp_q[$];
  logic [7:0]  tx_model[$];

  logic drop_en    = 1'b0;
  logic lo_pending = 1'b0;
  logic spi_dead   = 1'b0;
  int   status_polls = 0;
  int   busy_polls   = 0;
  logic [7:0] spi_shift = 8'h00;
  int   spi_cnt = 0;

  typedef struct {
    int         n;
    logic [7:0] base;
    bit         drop;
    bit         extra;
    bit         drain;
    logic [1:0] exp_err;
  } vec_t;
  vec_t vecs[5];

  spi_burst_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
    .go(go), .busy(busy), .done(done), .err(err),
    .io_req(io_req), .io_gnt(io_gnt),
    .io_cs(io_cs), .io_write(io_write), .io_read(io_read),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din)
  );

  // Clock.
  always #5 clk = ~clk;

  // IO block model: a start write arms the busy counter and latches the byte
  // that is looped back as the received data.
  always @(posedge clk) begin
    if (io_cs && io_write && io_addr == 14'd4 && io_dout[8]) begin
      spi_shift <= io_dout[7:0];
      spi_cnt   <= spi_dead ? 0 : BUSY_LEN + 1;
    end else if (spi_cnt != 0) begin
      spi_cnt <= spi_cnt - 1;
    end
  end

  always_comb begin
    io_din = 16'h0000;
    if (io_addr == 14'd9)      io_din = {15'b0, (spi_cnt != 0)};
    else if (io_addr == 14'd4) io_din = {8'h00, spi_shift};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event, expected one within the bound", name);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_err"},      32'(err), 32'd0);
    check({tag, "_io_req"},   32'(io_req), 32'd0);
    check({tag, "_strobes"},  32'({io_cs, io_write, io_read}), 32'd0);
    check({tag, "_io_addr"},  32'(io_addr), 32'd0);
    check({tag, "_io_dout"},  32'(io_dout), 32'd0);
    check({tag, "_tx_full"},  32'(tx_full), 32'd0);
    check({tag, "_rx_empty"}, 32'(rx_empty), 32'd1);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1;
    tx_data = b;
    @(posedge clk);
    #1 tx_wr = 1'b0;
    tx_model.push_back(b);
  endtask

  task automatic pulse_go();
    @(posedge clk);
    #1 go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic drain_rx();
    int cnt;
    int exp_n;
    cnt = 0;
    exp_n = rx_exp_q.size();
    while (!rx_empty && cnt < 40) begin
      if (rx_exp_q.size() == 0) fail("rx_unexpected_entry");
      else check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
      rx_rd = 1'b1;
      @(posedge clk);
      #1 rx_rd = 1'b0;
      cnt++;
    end
    check("rx_count", cnt, exp_n);
  endtask

  // Expected bus writes and RX bytes for a burst that takes len bytes from TX.
  task automatic expect_bytes(input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = tx_model.pop_front();
      wr_exp_q.push_back({8'h01, b});
      wr_exp_q.push_back({8'h00, b});
      if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int len;
    bit ok;
    for (int i = 0; i < v.n; i++) push_tx(8'(v.base + 8'(i)));
    if (v.n == DEPTH) check("tx_full_before_go", 32'(tx_full), 32'd1);
    len = tx_model.size();
    expect_bytes(len);
    drop_en = v.drop;
    lo_pending = 1'b0;
    status_polls = 0;
    busy_polls = 0;
    pulse_go();
    @(negedge clk);
    check("req_after_go", 32'({busy, io_req}), 32'd3);
    check("err_cleared_by_go", 32'(err), 32'd0);
    @(negedge clk);
    check("load_two_cycles_after_go", 32'({io_cs, io_write, io_dout[8]}), 32'd7);
    if (v.n == DEPTH) begin
      @(negedge clk);
      check("tx_full_after_first_load", 32'(tx_full), 32'd0);
    end
    if (v.extra) push_tx(8'h5A);
    wait_done(ok);
    if (!ok) begin
      fail("burst_done");
    end else begin
      check("busy_at_done", 32'(busy), 32'd1);
      check("io_req_at_done", 32'(io_req), 32'd0);
      check("burst_err", 32'(err), 32'(v.exp_err));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
    end
    if (!v.drop) check("busy_polls", busy_polls, BUSY_LEN * len);
    check("wr_q_empty", wr_exp_q.size(), 0);
    drop_en = 1'b0;
    if (v.drain) drain_rx();
  endtask

  initial begin : main
    bit ok;
    bit found;
    tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; go = 1'b0; io_gnt = 1'b1;

    //          n   base    drop  extra drain exp_err
    vecs[0] = '{1,  8'hA5, 1'b0, 1'b0, 1'b1, 2'b00};  // single byte
    vecs[1] = '{16, 8'h00, 1'b0, 1'b1, 1'b1, 2'b00};  // full FIFO, push mid-burst
    vecs[2] = '{3,  8'h30, 1'b1, 1'b0, 1'b1, 2'b00};  // grant toggling, 0x5A leftover first
    vecs[3] = '{15, 8'h40, 1'b0, 1'b0, 1'b0, 2'b00};  // pre-fill RX with 15
    vecs[4] = '{3,  8'h60, 1'b0, 1'b0, 1'b1, 2'b10};  // RX overflow

    fork
      // Bus monitor: write scoreboard, strobe gating, status poll counts.
      forever begin
        @(negedge clk);
        if (!io_gnt) check("no_strobe_without_gnt", 32'({io_cs, io_write, io_read}), 32'd0);
        if (io_cs && io_write) begin
          check("wr_addr", 32'(io_addr), 32'd4);
          if (wr_exp_q.size() == 0) fail("unexpected_bus_write");
          else check("wr_data", 32'(io_dout), 32'(wr_exp_q.pop_front()));
        end
        if (io_cs && io_read && io_addr == 14'd9) begin
          status_polls++;
          if (io_din[0]) busy_polls++;
        end
      end
      // Grant driver: drops the grant for 5 cycles across CLR and WAIT_LO.
      forever begin
        @(negedge clk);
        if (drop_en && io_cs && io_write && io_dout[8]) begin
          @(posedge clk);
          #1 io_gnt = 1'b0;
          repeat (5) @(posedge clk);
          #1 io_gnt = 1'b1;
          lo_pending = 1'b1;
        end else if (drop_en && lo_pending && io_cs && io_read && io_addr == 14'd9 && io_din[0]) begin
          @(posedge clk);
          #1 io_gnt = 1'b0;
          repeat (5) @(posedge clk);
          #1 io_gnt = 1'b1;
          lo_pending = 1'b0;
        end
      end
      begin
        #500000;
        $display("FAIL global_watchdog: got no end of test, expected one before the time limit");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset.
    #2 rst = 1'b1;
    #2 check_idle("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // Timeout: status never goes busy; only the first byte is loaded.
    spi_dead = 1'b1;
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    wr_exp_q.push_back({8'h01, tx_model[0]});
    wr_exp_q.push_back({8'h00, tx_model[0]});
    tx_model.delete();
    status_polls = 0;
    pulse_go();
    wait_done(ok);
    if (!ok) fail("timeout_done");
    else begin
      check("timeout_err", 32'(err), 32'd1);
      check("timeout_polls", status_polls, TIMEOUT);
    end
    @(negedge clk);
    check("timeout_busy_after", 32'(busy), 32'd0);
    // TX was flushed, so this go is ignored and err is kept.
    pulse_go();
    @(negedge clk);
    check("flushed_go_ignored", 32'({busy, io_req}), 32'd0);
    check("err_kept_on_ignored_go", 32'(err), 32'd1);
    spi_dead = 1'b0;
    run_burst('{1, 8'h77, 1'b0, 1'b0, 1'b1, 2'b00});

    // Reset in WAIT_LO.
    push_tx(8'h81); push_tx(8'h82);
    expect_bytes(2);
    pulse_go();
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (io_cs && io_read && io_addr == 14'd9 && io_din[0]) found = 1'b1;
    end
    if (!found) fail("reach_wait_lo");
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_idle("mid_burst_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    tx_model.delete();
    wr_exp_q.delete();
    rx_exp_q.delete();
    pulse_go();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("go_after_reset_ignored", 32'({busy, io_req}), 32'd0);
    end
    check("rx_empty_after_reset", 32'(rx_empty), 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_burst_sequencer.md
# spi_burst_sequencer

Bus-master controller that runs multi-byte SPI bursts through the IO block's register map without CPU polling. Software fills a TX FIFO and pulses `go`. For each byte the block writes the SPI data register with the start bit set, clears the start bit, polls the status register until the transfer completes, and reads the received byte into an RX FIFO. It requests the IO bus from the system bus arbiter and drives it only while granted.

## Interface
Parameters:
- `DEPTH`, 16: TX and RX FIFO depth in bytes; power of two, 2..256.
- `TIMEOUT`, 1023: maximum clk cycles spent in WAIT_HI or WAIT_LO before the burst aborts.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_wr`  in  1  push `tx_data` into the TX FIFO; ignored when `tx_full`.
- `tx_data`  in  8  byte to transmit.
- `tx_full`  out  1  TX FIFO full.
- `rx_rd`  in  1  pop the RX FIFO; ignored when `rx_empty`.
- `rx_data`  out  8  head of the RX FIFO, combinational from the head entry.
- `rx_empty`  out  1  RX FIFO empty.
- `go`  in  1  start a burst; accepted only in IDLE with TX non-empty, otherwise ignored.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at burst end, on success or abort.
- `err`  out  2  sticky status: bit0 = timeout, bit1 = RX overflow. Cleared on an accepted `go`.
- `io_req`  out  1  bus request to the arbiter.
- `io_gnt`  in  1  bus grant.
- `io_cs`, `io_write`, `io_read`  out  1 each  IO bus strobes.
- `io_addr`  out  14  IO register address; 4 = SPI data, 9 = status.
- `io_dout`  out  16  write data to IO.
- `io_din`  in  16  read data from IO; combinational, valid in the same cycle as `io_cs`/`io_addr`.

## Operation
- Bus-drive rule: `io_cs`, `io_write` and `io_read` may be high only when `io_gnt` is high. Otherwise all bus outputs are 0. Once `go` is accepted, `io_req` stays high until DONE.
- The burst length is the TX occupancy latched when `go` is accepted. Bytes pushed during a burst wait for the next `go`.
- States and transitions:
  - IDLE: on an accepted `go`, go to REQ.
  - REQ: when `io_gnt`, go to LOAD.
  - LOAD: write addr 4 with `io_dout = {7'b0, 1'b1, byte}`, where byte is the TX head. Pop TX. Go to CLR.
  - CLR: write addr 4 with `{7'b0, 1'b0, byte}`. Go to WAIT_HI.
  - WAIT_HI: read addr 9 every cycle. When `io_din[0]` = 1, go to WAIT_LO.
  - WAIT_LO: read addr 9 every cycle. When `io_din[0]` = 0, go to READ.
  - READ: read addr 4 and push `io_din[7:0]` into the RX FIFO. If RX is full, drop the byte and set `err[1]`; the burst continues. Decrement the remaining count. If the count is now 0, go to DONE; else go to LOAD.
  - DONE: pulse `done`, drop `io_req`, go to IDLE.
- Grant loss: if `io_gnt` falls in any state from LOAD to READ, the FSM holds its state with bus strobes at 0 and resumes when the grant returns. The timeout counter is frozen while ungranted. A hold in LOAD does not pop TX twice, because the pop happens only on the granted cycle.
- Timeout:
  - One counter, cleared on entry to WAIT_HI and again on entry to WAIT_LO.
  - On reaching `TIMEOUT`: set `err[0]`, flush the TX FIFO, go to DONE.
- FIFOs:
  - Pointers are log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
  - A simultaneous push and pop leaves occupancy unchanged; the pop on an empty FIFO and the push on a full FIFO are ignored.
  - An internal RX push and an external `rx_rd` in the same cycle are both honoured.
- Reset values: `busy`=0, `done`=0, `err`=0, `io_req`=0, `io_cs`/`io_write`/`io_read`=0, `io_addr`=0, `io_dout`=0. Both FIFOs are empty, so `tx_full`=0 and `rx_empty`=1. FSM is in IDLE.
- Reset mid-burst: immediate return to IDLE with FIFOs emptied. The SPI start bit in the IO block is not cleared by this block.

## Timing
- Bus outputs are registered from the state; `io_din` is sampled on the same edge that leaves READ, WAIT_HI or WAIT_LO.
- With `io_gnt` held high:
  - `go` to first LOAD: 2 cycles (IDLE→REQ→LOAD).
  - Per-byte overhead beyond the SPI transfer: 4 cycles (LOAD, CLR, READ, plus at least one WAIT_HI cycle), plus at least one WAIT_LO cycle.
  - `done` asserts the cycle after the last READ; `busy` falls the cycle after `done`.
- `go` during a burst has no effect and does not clear `err`.

## Test plan
- Single byte, loopback MISO model with busy high for 8 cycles. Push 0xA5, `go` → LOAD writes 0x1A5 to addr 4, CLR writes 0x0A5, 8 status polls return 1, READ captures 0xA5. RX holds 0xA5, `done` pulses once, `err`=0.
- 16-byte burst with DEPTH=16. Push 0x00..0x0F, `go` → `tx_full` falls after the first LOAD. RX receives 0x00..0x0F in order, then `rx_empty`=0 with 16 entries. A byte pushed mid-burst remains in TX after `done`.
- Grant toggling: drop `io_gnt` for 5 cycles during CLR and again during WAIT_LO → no strobes while ungranted, no duplicate TX pop, result identical to the uninterrupted run.
- Timeout, TIMEOUT=20, busy never asserts → after 20 WAIT_HI cycles `err`=01, TX is flushed, `done` pulses. A following accepted `go` clears `err`.
- RX overflow: RX pre-filled with 15 entries, 3-byte burst → the first byte is stored, the 2nd and 3rd are dropped, `err`=10, `done` pulses.
- Reset asserted in WAIT_LO → all outputs at reset values within the same cycle, both FIFOs empty; a new `go` after reset with TX empty is ignored.
